// File: rtl/rf_pkg.sv
// Shared constants and types for the RiSC register file with its pending-write
// scoreboard. Default sizes are set here. The top module and the interface
// take these values as their parameter defaults.
package rf_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_NREGS  = 8;
    localparam int RF_ADDR_W = $clog2(RF_NREGS);
    localparam int RF_NRD    = 2;
    localparam int RF_CNT_W  = 2;

    // Register 0 is hardwired to zero and is never pending.
    localparam int ZERO_REG  = 0;
    // Saturation value of a pending counter at the default width.
    localparam int CNT_MAX   = 2**RF_CNT_W - 1;

    // Per-cycle action taken by one pending counter.
    typedef enum logic [1:0] {
        CTR_HOLD  = 2'd0,
        CTR_INC   = 2'd1,
        CTR_DEC   = 2'd2,
        CTR_UFLOW = 2'd3
    } ctr_op_e;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundles the read, reservation and writeback signals of regfile_scoreboard.
// The master modport is the pipeline side and the slave modport is the register file.
interface regfile_scoreboard_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NRD    = RF_NRD
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  rsv_en;
    logic [ADDR_W-1:0]     rsv_tgt;
    logic                  rsv_rdy;
    logic                  we_reg;
    logic [ADDR_W-1:0]     tgt;
    logic [DATA_W-1:0]     write_data;
    logic                  wb_err;

    modport master (
        output rd_addr, rsv_en, rsv_tgt, we_reg, tgt, write_data,
        input  rd_data, rd_busy, rsv_rdy, wb_err
    );

    modport slave (
        input  rd_addr, rsv_en, rsv_tgt, we_reg, tgt, write_data,
        output rd_data, rd_busy, rsv_rdy, wb_err
    );
endinterface

// File: rtl/rf_pending_ctr.sv
// Saturating up/down counter that tracks the writes still in flight to one register.
// When inc and dec arrive in the same cycle they cancel and the count holds.
// When dec arrives while the count is zero, underflow is flagged and the count stays at zero.
module rf_pending_ctr
    import rf_pkg::*;
#(
    parameter int CNT_W = RF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             underflow
);
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    ctr_op_e op;

    assign full      = (cnt == MAX);
    assign underflow = dec && (cnt == '0);

    // Select this cycle's action. The caller already gates inc with full; the check here is a backstop.
    always_comb begin
        op = CTR_HOLD;
        if (inc && !dec && !full) begin
            op = CTR_INC;
        end else if (dec && !inc) begin
            op = (cnt == '0) ? CTR_UFLOW : CTR_DEC;
        end
    end

    // Counter state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case (op)
                CTR_INC: cnt <= cnt + CNT_W'(1);
                CTR_DEC: cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// RiSC general-purpose register file. It has NRD combinational read ports and one
// synchronous writeback port. A per-register pending-write scoreboard lets issue
// logic detect RAW hazards.
// Optional feature: define RF_BYPASS_EN to enable write-first forwarding from the
// writeback port to the read ports.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int NREGS  = RF_NREGS,
    parameter int ADDR_W = $clog2(NREGS),
    parameter int NRD    = RF_NRD,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_scoreboard_if.slave   bus
);
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs    [NREGS];
    logic [CNT_W-1:0]  cnt_arr [NREGS];
    logic [NREGS-1:0]  full_vec;
    logic [NREGS-1:0]  uflow_vec;
    logic              rsv_acc;
    logic              wb_hit;
    logic              wb_err_reg;

    // Register 0 has no counter. It is never pending and never refuses a reservation.
    assign cnt_arr[0]   = '0;
    assign full_vec[0]  = 1'b0;
    assign uflow_vec[0] = 1'b0;

    // Readiness uses the count from before the clock edge. A writeback in the same cycle does not free a slot.
    assign bus.rsv_rdy = (bus.rsv_tgt == ZERO_IDX) || !full_vec[bus.rsv_tgt];
    assign rsv_acc     = bus.rsv_en && bus.rsv_rdy;
    assign wb_hit      = bus.we_reg && (bus.tgt != ZERO_IDX);
    assign bus.wb_err  = wb_err_reg;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_ctr
            rf_pending_ctr #(.CNT_W(CNT_W)) u_ctr (
                .clk       (clk),
                .rst_n     (rst_n),
                .inc       (rsv_acc && (bus.rsv_tgt == ADDR_W'(gi))),
                .dec       (wb_hit && (bus.tgt == ADDR_W'(gi))),
                .cnt       (cnt_arr[gi]),
                .full      (full_vec[gi]),
                .underflow (uflow_vec[gi])
            );
        end
    endgenerate

    // Register storage. Writes to index 0 are filtered out by wb_hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[bus.tgt] <= bus.write_data;
        end
    end

    // Sticky flag set by a writeback that had no outstanding reservation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_err_reg <= 1'b0;
        end else if (|uflow_vec) begin
            wb_err_reg <= 1'b1;
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              fwd;

            assign addr = bus.rd_addr[gi*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
            assign fwd = wb_hit && (bus.tgt == addr);
`else
            assign fwd = 1'b0;
`endif
            assign bus.rd_data[gi*DATA_W +: DATA_W] =
                (addr == ZERO_IDX) ? '0 : (fwd ? bus.write_data : regs[addr]);
            // A forwarded writeback that completes the last pending write makes the register non-busy.
            assign bus.rd_busy[gi] = (cnt_arr[addr] != '0) &&
                                     !(fwd && (cnt_arr[addr] == CNT_W'(1)));
        end
    endgenerate
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised general-purpose register file for the pipelined RiSC core. It has NRD asynchronous read ports and one synchronous writeback port. A per-register pending-write scoreboard holds a saturating counter per register, so issue logic can detect RAW hazards and stall. Register 0 always reads zero and is never pending.

Parameters:
DATA_W, 16, register width in bits
NREGS, 8, number of architectural registers (power of two, >=2)
ADDR_W, $clog2(NREGS), register index width
NRD, 2, number of read ports (1..4)
CNT_W, 2, width of each pending counter; max in-flight writes per register = 2**CNT_W-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*ADDR_W  read indices, port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NRD*DATA_W  read values, port k at [k*DATA_W +: DATA_W]
rd_busy  out  NRD  port k register has outstanding pending writes
rsv_en  in  1  issue request: reserve rsv_tgt as destination
rsv_tgt  in  ADDR_W  destination index being reserved
rsv_rdy  out  1  reservation accepted this cycle (combinational)
we_reg  in  1  writeback enable
tgt  in  ADDR_W  writeback index
write_data  in  DATA_W  writeback value
wb_err  out  1  sticky: writeback arrived with no pending reservation

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: all registers = 0, all counters = 0, wb_err = 0. rd_data then reads 0 and rd_busy reads 0.
- Reads are combinational: rd_data[k] = regs[rd_addr[k]]. Index 0 always returns 0.
- Write: on the clk rising edge with we_reg=1 and tgt!=0, regs[tgt] <= write_data. A write to tgt=0 is discarded and does not affect counters or wb_err.
- Counters: cnt[r] for r=1..NREGS-1; cnt[0] is constant 0.
  - A reservation is accepted when rsv_en & rsv_rdy.
  - rsv_rdy = 1 when rsv_tgt==0 or cnt[rsv_tgt] < 2**CNT_W-1. Otherwise rsv_rdy = 0 and the request is ignored; the requester holds its request and retries.
  - An accepted reservation to a nonzero index increments the counter. A reservation to index 0 is always accepted and changes nothing.
  - A writeback with we_reg=1, tgt!=0 and cnt[tgt]>0 decrements the counter.
  - A writeback with cnt[tgt]==0 writes the data anyway, leaves the counter at 0 and sets wb_err. wb_err clears only on reset.
- Same register reserved and written back in one cycle: the counter is unchanged (+1-1). rsv_rdy is still evaluated on the pre-edge count, so a saturated counter refuses the reservation even when a writeback to it is present.
- rd_busy[k] = (cnt[rd_addr[k]] != 0). This is pre-edge state; the writeback in the current cycle does not clear it.
- Multiple read ports may address the same register; each returns the identical value.
- Reset asserted mid-operation discards all pending counts and in-flight state immediately.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-first forwarding. If we_reg=1, tgt!=0 and rd_addr[k]==tgt, then rd_data[k] = write_data in the same cycle. rd_busy[k] is also forced to 0 when cnt[tgt]==1, because the last pending write is completing.
- Undefined: reads return the pre-edge register contents, and rd_busy follows the pre-edge count only.

Decomposition:
- Package rf_pkg: DATA_W and NREGS defaults, the derived ADDR_W, CNT_W, the constant ZERO_REG = 0, and the saturation constant CNT_MAX = 2**CNT_W-1.
- One sub-module, rf_pending_ctr: per-register saturating up/down counter with inputs inc, dec and async rst_n, and outputs cnt, full, underflow. It is instantiated NREGS-1 times with a generate loop. The data array and read muxes stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-run after writing r3=0x1234 -> rd_data on all ports = 0x0000, rd_busy = 0, wb_err = 0 immediately, without waiting for a clock edge.
- Basic write/read: we_reg=1, tgt=5, write_data=0xBEEF, then rd_addr port0=5 and port1=0 -> the next cycle reads 0xBEEF and 0x0000. A write to tgt=0 with data 0xFFFF -> r0 still reads 0.
- Scoreboard saturation (CNT_W=2): reserve r2 three times -> rd_busy=1 and a 4th rsv_rdy=0. Three writebacks to r2 -> rd_busy=0 after the 3rd edge.
- Simultaneous reserve and writeback: r4 count=1, with rsv_tgt=4 and tgt=4 in the same cycle -> count stays 1 and rd_busy for r4 stays 1.
- Underflow: writeback tgt=6 with count 0 and data 0x0042 -> r6=0x0042 and wb_err=1 sticky until reset.
- Bypass (RF_BYPASS_EN): rd_addr=7 with we_reg=1, tgt=7, data 0xA5A5 -> rd_data=0xA5A5 in the same cycle. Without the macro -> the old value is read.
